// File: rtl/uart_tx.sv
// uart_tx -- 8N1 UART transmitter.
//
// Sends one frame per accepted start request: a low start bit, eight data
// bits LSB first, then a high stop bit. Every bit lasts exactly
// CLOCKS_PER_BAUD clock cycles. All outputs are registered.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset; abandons any frame in progress
//   data_i   byte to send, sampled only in the cycle start_i is accepted
//   start_i  one-cycle transmit request; ignored while a frame is running
//   done_o   one-cycle pulse in the cycle after the stop bit completes
//   tx       serial line, idles high
module uart_tx #(
   parameter int unsigned CLOCKS_PER_BAUD = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_i,
   input  logic       start_i,
   output logic       done_o,
   output logic       tx
);

   localparam int unsigned CW = (CLOCKS_PER_BAUD > 1) ? $clog2(CLOCKS_PER_BAUD) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_BAUD - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_baud_cnt;
   logic [2:0]      r_bit_idx;
   logic [7:0]      r_shift;
   logic            r_tx;
   logic            r_done;

   logic            w_baud_last;
   logic [2:0]      w_next_idx;

   assign w_baud_last = (r_baud_cnt == CNT_LAST);
   assign w_next_idx  = r_bit_idx + 3'd1;

   assign tx     = r_tx;
   assign done_o = r_done;

   // tx is registered, so each state loads the level for the *next* bit
   // on the edge that ends the current one; the line therefore changes
   // exactly on bit boundaries with no extra cycle of latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_baud_cnt <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_tx       <= 1'b1;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_tx <= 1'b1;
               if (start_i) begin
                  r_shift    <= data_i;
                  r_baud_cnt <= '0;
                  r_bit_idx  <= '0;
                  r_tx       <= 1'b0;
                  r_state    <= S_START;
               end
            end

            S_START: begin
               if (w_baud_last) begin
                  r_baud_cnt <= '0;
                  r_bit_idx  <= '0;
                  r_tx       <= r_shift[0];
                  r_state    <= S_DATA;
               end else begin
                  r_baud_cnt <= r_baud_cnt + CW'(1);
               end
            end

            S_DATA: begin
               if (w_baud_last) begin
                  r_baud_cnt <= '0;
                  if (r_bit_idx == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= S_STOP;
                  end else begin
                     r_bit_idx <= w_next_idx;
                     r_tx      <= r_shift[w_next_idx];
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + CW'(1);
               end
            end

            S_STOP: begin
               if (w_baud_last) begin
                  r_baud_cnt <= '0;
                  r_tx       <= 1'b1;
                  r_done     <= 1'b1;
                  r_state    <= S_IDLE;
               end else begin
                  r_baud_cnt <= r_baud_cnt + CW'(1);
               end
            end

            default: begin
               r_baud_cnt <= '0;
               r_tx       <= 1'b1;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- self-checking bench for uart_tx.
//
// Two instances: one at the default 868 clocks per bit, one at 4 clocks per
// bit for back-to-back and randomized frames. The expected line level for
// cycle n of a frame is bit (n-1)/C of the 10-bit frame {stop, data, start}.
module tb_uart_tx;

   localparam int CA = 868;
   localparam int CB = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data_a, data_b;
   logic       start_a, start_b;
   logic       tx_a, tx_b;
   logic       done_a, done_b;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   uart_tx #(.CLOCKS_PER_BAUD(CA)) u_dut_a (
      .clk     (clk),
      .rst     (rst),
      .data_i  (data_a),
      .start_i (start_a),
      .done_o  (done_a),
      .tx      (tx_a)
   );

   uart_tx #(.CLOCKS_PER_BAUD(CB)) u_dut_b (
      .clk     (clk),
      .rst     (rst),
      .data_i  (data_b),
      .start_i (start_b),
      .done_o  (done_b),
      .tx      (tx_b)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   // Line level in cycle n (1..10c) of a frame carrying byte b.
   function automatic logic exp_tx(input logic [7:0] b, input int n, input int c);
      logic [9:0] fr;
      fr = {1'b1, b, 1'b0};
      return fr[(n - 1) / c];
   endfunction

   function automatic int clocks(input int sel);
      return (sel == 0) ? CA : CB;
   endfunction

   function automatic logic get_tx(input int sel);
      return (sel == 0) ? tx_a : tx_b;
   endfunction

   function automatic logic get_done(input int sel);
      return (sel == 0) ? done_a : done_b;
   endfunction

   task automatic drive(input int sel, input logic s, input logic [7:0] d);
      if (sel == 0) begin
         start_a = s;
         data_a  = d;
      end else begin
         start_b = s;
         data_b  = d;
      end
   endtask

   // Both lines idle high, no done pulses, for ncyc cycles.
   task automatic idle_check(input int ncyc, input string tag);
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         chk({tag, "/a_tx"},   tx_a,   1'b1);
         chk({tag, "/a_done"}, done_a, 1'b0);
         chk({tag, "/b_tx"},   tx_b,   1'b1);
         chk({tag, "/b_done"}, done_b, 1'b0);
      end
   endtask

   // Called at a negedge where the DUT is idle (or in its done cycle).
   // Requests byte b, keeps start high for 'hold' cycles in total, injects a
   // busy start with inj_d in cycle inj_at, scrambles data_i every cycle,
   // and checks tx/done every cycle. Returns at the negedge of the done
   // cycle, or of cycle stop_at when nonzero.
   task automatic frame(input int sel, input logic [7:0] b, input int hold,
                        input int inj_at, input logic [7:0] inj_d,
                        input int stop_at, input string tag);
      int c;
      int last;
      c    = clocks(sel);
      last = 10 * c + 1;
      drive(sel, 1'b1, b);
      for (int n = 1; n <= last; n++) begin
         @(negedge clk);
         if (n <= 10 * c)
            chk({tag, "/tx"}, get_tx(sel), exp_tx(b, n, c));
         else
            chk({tag, "/tx_idle"}, get_tx(sel), 1'b1);
         chk({tag, "/done"}, get_done(sel), logic'(n == last));
         if (stop_at != 0 && n == stop_at) return;
         if (n == inj_at)
            drive(sel, 1'b1, inj_d);
         else if (n < hold)
            drive(sel, 1'b1, 8'($urandom));
         else
            drive(sel, 1'b0, 8'($urandom));
      end
   endtask

   initial begin
      logic [7:0] b;
      int         gap;
      int         inj;

      rst     = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      data_a  = '0;
      data_b  = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst/a_tx",   tx_a,   1'b1);
      chk("rst/a_done", done_a, 1'b0);
      chk("rst/b_tx",   tx_b,   1'b1);
      chk("rst/b_done", done_b, 1'b0);
      rst = 1'b0;
      idle_check(1000, "post_rst");

      // Asynchronous reset between edges while idle
      #2 rst = 1'b1;
      #1;
      chk("async_rst/a_tx",   tx_a,   1'b1);
      chk("async_rst/a_done", done_a, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      idle_check(5, "async_rel");

      // 0xFF, start held for 3 cycles (only the first counts)
      frame(0, 8'hFF, 3, 0, 8'h00, 0, "ff");
      idle_check(20, "ff_after");

      // 0x81
      frame(0, 8'h81, 1, 0, 8'h00, 0, "x81");
      idle_check(20, "x81_after");

      // 0xA5 with a 0x00 start request in cycle 3000
      frame(0, 8'hA5, 1, 3000, 8'h00, 0, "a5_busy");
      idle_check(50, "a5_no_second");

      // Reset in the middle of data bit 3
      frame(0, 8'h5A, 1, 0, 8'h00, 4 * CA + CA / 2, "abort");
      #2 rst = 1'b1;
      #1;
      chk("abort/tx",   tx_a,   1'b1);
      chk("abort/done", done_a, 1'b0);
      drive(0, 1'b0, 8'h00);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle_check(6 * CA, "abort_quiet");
      frame(0, 8'($urandom), 1, 0, 8'h00, 0, "fresh");
      idle_check(5, "fresh_after");

      // Back-to-back at 4 clocks per bit: 0x55 then 0x3C in its done cycle
      frame(1, 8'h55, 1, 0, 8'h00, 0, "b2b_55");
      frame(1, 8'h3C, 1, 0, 8'h00, 0, "b2b_3c");
      idle_check(10, "b2b_after");

      // Randomized frames with random gaps and busy-time start requests
      for (int i = 0; i < 40; i++) begin
         b   = 8'($urandom);
         inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 10 * CB - 1)) : 0;
         frame(1, b, int'($urandom_range(1, 3)), inj, 8'($urandom), 0, "rand");
         gap = int'($urandom_range(0, 4));
         if (gap != 0) idle_check(gap, "rand_gap");
      end
      idle_check(20, "end_idle");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter producing 8N1 serial frames: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. It sits between a byte-producing controller and the FPGA TX pin.
- Default timing: 100 MHz clock, 115200 baud (CLOCKS_PER_BAUD=868).
- Handshake: single-cycle start strobe in, single-cycle done strobe out.

Parameters:
- CLOCKS_PER_BAUD, 868, clock cycles per serial bit period; legal range is 2 or greater.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_i  input  8  byte to send; sampled only on the cycle start_i is accepted.
- start_i  input  1  one-cycle request to transmit data_i.
- done_o  output  1  one-cycle pulse when a frame, including its stop bit, has completed.
- tx  output  1  serial line; idles high.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any time, including mid-frame):
  - State becomes IDLE, tx=1, done_o=0.
  - Baud counter and bit index clear to 0.
  - The frame in progress is abandoned; nothing resumes after reset releases.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1.
  - If start_i=1 at a rising edge: latch data_i into an internal shift register, clear the baud counter, go to START.
- START: tx=0 for exactly CLOCKS_PER_BAUD cycles, then go to DATA with bit index 0.
- DATA:
  - tx=shift[bit index], LSB first. Each bit is held for exactly CLOCKS_PER_BAUD cycles.
  - After bit 7, go to STOP.
- STOP: tx=1 for exactly CLOCKS_PER_BAUD cycles, then return to IDLE with done_o=1 for that single cycle.
- Cycle-level timing, with start_i accepted at rising edge of cycle 0 (C=CLOCKS_PER_BAUD):
  - Start bit: cycles 1..C.
  - Data bit k: cycles (k+1)C+1..(k+2)C.
  - Stop bit: cycles 9C+1..10C.
  - done_o=1 in cycle 10C+1 only.
  - A frame occupies exactly 10C cycles.
- Baud counter:
  - Width $clog2(CLOCKS_PER_BAUD).
  - Counts 0..C-1, then wraps to 0 and advances the bit/state.
  - No drift: every bit is exactly C cycles.
- Busy behaviour:
  - start_i is ignored in START, DATA and STOP; there is no queuing.
  - Changes to data_i mid-frame do not affect the frame.
- Back-to-back frames:
  - In the done_o cycle the FSM is already IDLE, so start_i asserted in that cycle is accepted.
  - The next start bit then begins in the following cycle (zero idle gap).
- start_i held high for multiple cycles while IDLE: only the first cycle starts a frame. If it is still high when done_o is asserted, a new frame starts.
- done_o never asserts outside the single cycle after a completed stop bit. It does not assert after a reset-aborted frame.

Test Plan:
- Reset:
  - Assert rst asynchronously between clock edges. tx=1 and done_o=0 immediately.
  - Release rst. tx stays 1 with no spurious done_o for 1000 cycles.
- data_i=0xFF, start pulse 1 cycle, CLOCKS_PER_BAUD=868:
  - tx=0 for cycles 1..868, then 1 for cycles 869..8680.
  - done_o=1 only at cycle 8681.
- data_i=0x81:
  - tx samples at each bit centre are 0 (start), 1,0,0,0,0,0,0,1 (data), 1 (stop).
  - Frame length 8680 cycles; single done_o pulse.
- Start while busy:
  - Pulse start_i with data_i=0x00 at cycle 3000 of a 0xA5 frame.
  - Line still carries 0xA5 bits (1,0,1,0,0,1,0,1); exactly one done_o; no second frame.
- Back-to-back, CLOCKS_PER_BAUD=4:
  - Assert start_i with 0x3C in the done_o cycle of a 0x55 frame.
  - Second start bit begins the next cycle; both frames are bit-exact at 40 cycles each.
- Reset mid-frame:
  - Assert rst during data bit 3.
  - tx=1 at once, no done_o; the next start transmits a fresh, complete frame.
